program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_pkg.sv | 53 +++++
 rtl/program_loader.sv | 92 +++++++++
 tb/tb_program_loader.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader and the processor decode stage:
// command opcodes, instruction-word opcodes, loader states and the word encoder.
package program_loader_pkg;

   localparam int IMEM_DEPTH = 128;

   typedef enum logic [2:0] {
      OP_NOOP  = 3'd0,
      OP_STORE = 3'd1,
      OP_LOAD  = 3'd2,
      OP_ADD   = 3'd3,
      OP_SUB   = 3'd4,
      OP_HALT  = 3'd5
   } op_e;

   localparam logic [3:0] INSTR_NOOP  = 4'h0;
   localparam logic [3:0] INSTR_STORE = 4'h1;
   localparam logic [3:0] INSTR_LOAD  = 4'h2;
   localparam logic [3:0] INSTR_ADD   = 4'h3;
   localparam logic [3:0] INSTR_SUB   = 4'h4;
   localparam logic [3:0] INSTR_HALT  = 4'h5;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ACCEPT = 3'd1,
      ST_WRITE  = 3'd2,
      ST_DONE   = 3'd3,
      ST_FULL   = 3'd4
   } ld_state_e;

   // Reserved opcodes 6/7 fall into the default arm and become HALT words.
   function automatic logic [15:0] encode(input logic [2:0] op,
                                          input logic [3:0] ra,
                                          input logic [3:0] rb,
                                          input logic [3:0] rw,
                                          input logic [7:0] daddr);
      logic [15:0] word;
      case (op)
         OP_NOOP:  word = {INSTR_NOOP, 12'h000};
         OP_STORE: word = {INSTR_STORE, ra, daddr};
         OP_LOAD:  word = {INSTR_LOAD, daddr, rw};
         OP_ADD:   word = {INSTR_ADD, ra, rb, rw};
         OP_SUB:   word = {INSTR_SUB, ra, rb, rw};
         default:  word = {INSTR_HALT, 12'h000};
      endcase
      return word;
   endfunction

   function automatic logic is_terminal(input logic [2:0] op);
      return (op >= OP_HALT);
   endfunction

endpackage

// File: rtl/program_loader.sv
// Streams encoded commands into instruction memory, one word per two cycles,
// holding the processor in reset until a HALT terminates the program.
module program_loader
   import program_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [2:0]  cmd_op,
   input  logic [3:0]  cmd_ra,
   input  logic [3:0]  cmd_rb,
   input  logic [3:0]  cmd_rw,
   input  logic [7:0]  cmd_daddr,
   output logic        I_wr,
   output logic [6:0]  I_addr,
   output logic [15:0] I_data,
   output logic        cpu_hold,
   output logic        done,
   output logic        full,
   output logic [7:0]  count
);

   ld_state_e   r_state;
   ld_state_e   w_next;
   logic [6:0]  r_addr;
   logic [15:0] r_data;
   logic [7:0]  r_count;
   logic        r_halt;
   logic        w_xfer;
   logic        w_begin;
   logic        w_last_addr;

   assign w_xfer      = cmd_valid && (r_state == ST_ACCEPT);
   assign w_begin     = start && (r_state == ST_IDLE || r_state == ST_DONE ||
                                  r_state == ST_FULL);
   assign w_last_addr = (r_addr == 7'(IMEM_DEPTH - 1));

   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:   if (start) w_next = ST_ACCEPT;
         ST_ACCEPT: if (cmd_valid) w_next = ST_WRITE;
         ST_WRITE: begin
            if (r_halt)           w_next = ST_DONE;
            else if (w_last_addr) w_next = ST_FULL;
            else                  w_next = ST_ACCEPT;
         end
         ST_DONE:   if (start) w_next = ST_ACCEPT;
         ST_FULL:   if (start) w_next = ST_ACCEPT;
         default:   w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = (r_state == ST_ACCEPT);
      I_wr      = (r_state == ST_WRITE);
      done      = (r_state == ST_DONE);
      full      = (r_state == ST_FULL);
      cpu_hold  = (r_state != ST_DONE);
   end

   // Address, word and count advance only on transfer / write completion.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_addr  <= '0;
         r_data  <= '0;
         r_count <= '0;
         r_halt  <= 1'b0;
      end else if (w_begin) begin
         r_addr  <= '0;
         r_count <= '0;
      end else if (w_xfer) begin
         r_data <= encode(cmd_op, cmd_ra, cmd_rb, cmd_rw, cmd_daddr);
         r_halt <= is_terminal(cmd_op);
      end else if (r_state == ST_WRITE) begin
         r_count <= r_count + 8'd1;
         if (!r_halt && !w_last_addr) r_addr <= r_addr + 7'd1;
      end
   end

   assign I_addr = r_addr;
   assign I_data = r_data;
   assign count  = r_count;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a table of commands with hand-encoded
// words, plus sequences for fill-to-full, reset mid-write and start handling.
module tb_program_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [3:0]  cmd_ra;
   logic [3:0]  cmd_rb;
   logic [3:0]  cmd_rw;
   logic [7:0]  cmd_daddr;
   logic        I_wr;
   logic [6:0]  I_addr;
   logic [15:0] I_data;
   logic        cpu_hold;
   logic        done;
   logic        full;
   logic [7:0]  count;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   program_loader dut (
      .clk(clk), .reset(reset), .start(start),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rw(cmd_rw), .cmd_daddr(cmd_daddr),
      .I_wr(I_wr), .I_addr(I_addr), .I_data(I_data), .cpu_hold(cpu_hold),
      .done(done), .full(full), .count(count)
   );

   typedef struct {
      logic [2:0]  op;
      logic [3:0]  ra;
      logic [3:0]  rb;
      logic [3:0]  rw;
      logic [7:0]  da;
      logic [6:0]  addr;
      logic [15:0] word;
      logic [7:0]  cnt;
      logic        term;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Called at a falling edge; checks the write cycle and the cycle after it.
   task automatic send(input vec_t v);
      int waitc = 0;
      while (!cmd_ready && waitc < 10) begin
         @(negedge clk);
         waitc++;
      end
      if (!cmd_ready) begin
         chk("ready_wait", cmd_ready, 1);
         return;
      end
      cmd_valid = 1'b1;
      cmd_op    = v.op;
      cmd_ra    = v.ra;
      cmd_rb    = v.rb;
      cmd_rw    = v.rw;
      cmd_daddr = v.da;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("wr_strobe", I_wr, 1);
      chk("wr_addr", I_addr, v.addr);
      chk("wr_data", I_data, v.word);
      chk("ready_in_write", cmd_ready, 0);
      @(negedge clk);
      chk("wr_single", I_wr, 0);
      chk("count", count, v.cnt);
      chk("ready_after", cmd_ready, v.term ? 0 : 1);
      chk("done_after", done, v.term);
   endtask

   initial begin
      vec_t v;
      int nwr;
      int extra;

      reset = 1'b0; start = 1'b0; cmd_valid = 1'b0;
      cmd_op = '0; cmd_ra = '0; cmd_rb = '0; cmd_rw = '0; cmd_daddr = '0;

      vecs[0] = '{3'd1, 4'hF, 4'h0, 4'h0, 8'h29, 7'd0, 16'h1F29, 8'd1, 1'b0};
      vecs[1] = '{3'd2, 4'h0, 4'h0, 4'h7, 8'h0A, 7'd1, 16'h20A7, 8'd2, 1'b0};
      vecs[2] = '{3'd4, 4'h1, 4'h2, 4'h3, 8'h00, 7'd2, 16'h4123, 8'd3, 1'b0};
      vecs[3] = '{3'd3, 4'hA, 4'hB, 4'hC, 8'hFF, 7'd3, 16'h3ABC, 8'd4, 1'b0};
      vecs[4] = '{3'd0, 4'h5, 4'h6, 4'h7, 8'h88, 7'd4, 16'h0000, 8'd5, 1'b0};
      vecs[5] = '{3'd5, 4'h9, 4'h9, 4'h9, 8'h99, 7'd5, 16'h5000, 8'd6, 1'b1};

      // Reset state
      do_reset();
      chk("rst_ready", cmd_ready, 0);
      chk("rst_wr", I_wr, 0);
      chk("rst_addr", I_addr, 0);
      chk("rst_data", I_data, 0);
      chk("rst_count", count, 0);
      chk("rst_done", done, 0);
      chk("rst_full", full, 0);
      chk("rst_hold", cpu_hold, 1);

      // Single ADD with latency checks
      pulse_start();
      chk("accept_ready", cmd_ready, 1);
      send('{3'd3, 4'h1, 4'h2, 4'h3, 8'h00, 7'd0, 16'h3123, 8'd1, 1'b0});

      // Table: new session, mixed ops terminated by HALT
      do_reset();
      pulse_start();
      for (int i = 0; i < 6; i++) send(vecs[i]);
      chk("halt_hold", cpu_hold, 0);
      chk("halt_full", full, 0);

      // start in DONE opens a new session; start in ACCEPT is ignored
      pulse_start();
      chk("restart_done", done, 0);
      chk("restart_count", count, 0);
      chk("restart_hold", cpu_hold, 1);
      send('{3'd3, 4'h1, 4'h1, 4'h1, 8'h00, 7'd0, 16'h3111, 8'd1, 1'b0});
      pulse_start();
      chk("start_ign_ready", cmd_ready, 1);
      send('{3'd1, 4'h2, 4'h0, 4'h0, 8'h44, 7'd1, 16'h1244, 8'd2, 1'b0});

      // Reserved opcode 7 after two NOOPs
      do_reset();
      pulse_start();
      send('{3'd0, 4'h0, 4'h0, 4'h0, 8'h00, 7'd0, 16'h0000, 8'd1, 1'b0});
      send('{3'd0, 4'h0, 4'h0, 4'h0, 8'h00, 7'd1, 16'h0000, 8'd2, 1'b0});
      send('{3'd7, 4'h3, 4'h4, 4'h5, 8'h12, 7'd2, 16'h5000, 8'd3, 1'b1});
      chk("rsv7_hold", cpu_hold, 0);

      // Reserved opcode 6 terminates immediately
      pulse_start();
      send('{3'd6, 4'h3, 4'h4, 4'h5, 8'h12, 7'd0, 16'h5000, 8'd1, 1'b1});

      // Reset during WRITE
      do_reset();
      pulse_start();
      cmd_valid = 1'b1; cmd_op = 3'd3; cmd_ra = 4'h1; cmd_rb = 4'h2; cmd_rw = 4'h3;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("midwr_strobe", I_wr, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midwr_wr_off", I_wr, 0);
      chk("midwr_addr", I_addr, 0);
      chk("midwr_hold", cpu_hold, 1);
      chk("midwr_ready", cmd_ready, 0);
      chk("midwr_count", count, 0);
      @(negedge clk);
      chk("midwr_idle_ready", cmd_ready, 0);
      pulse_start();
      send('{3'd4, 4'h4, 4'h5, 4'h6, 8'h00, 7'd0, 16'h4456, 8'd1, 1'b0});

      // 128 NOOPs with valid held high: fill to FULL, no wrap
      do_reset();
      pulse_start();
      cmd_valid = 1'b1; cmd_op = 3'd0;
      nwr = 0;
      for (int c = 0; c < 400 && !full; c++) begin
         @(negedge clk);
         if (I_wr) begin
            chk("fill_addr", I_addr, nwr);
            nwr++;
         end
      end
      chk("fill_writes", nwr, 128);
      chk("fill_full", full, 1);
      chk("fill_hold", cpu_hold, 1);
      chk("fill_addr_end", I_addr, 127);
      chk("fill_ready", cmd_ready, 0);
      chk("fill_count", count, 128);
      extra = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (I_wr) extra++;
      end
      chk("fill_no_more", extra, 0);
      chk("fill_addr_stay", I_addr, 127);
      cmd_valid = 1'b0;

      // start in FULL begins a new session
      pulse_start();
      chk("full_restart", full, 0);
      chk("full_restart_count", count, 0);
      send('{3'd2, 4'h0, 4'h0, 4'h1, 8'hC3, 7'd0, 16'h2C31, 8'd1, 1'b0});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
